// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit between the core and a handshaked data-memory port.
// Accepts one access at a time, aligns store data into byte lanes, builds the
// write mask, extends load data, and flags misaligned/illegal/timed-out accesses.
module lsu_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_wen,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_rdata
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t              state_reg, state_next;
  logic                wen_reg, wen_next;
  logic [1:0]          size_reg, size_next;
  logic                uns_reg, uns_next;
  logic [OFF_W-1:0]    off_reg, off_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                req_ready_reg, req_ready_next;
  logic                resp_valid_reg, resp_valid_next;
  logic [DATA_W-1:0]   rdata_reg, rdata_next;
  logic                err_reg, err_next;
  logic                mreq_valid_reg, mreq_valid_next;
  logic                mreq_wen_reg, mreq_wen_next;
  logic [ADDR_W-1:0]   maddr_reg, maddr_next;
  logic [DATA_W-1:0]   mwdata_reg, mwdata_next;
  logic [NB-1:0]       mwmask_reg, mwmask_next;

  // Request-side decode; only consumed when a request is accepted in IDLE.
  logic [OFF_W-1:0]    off_in;
  logic                bad_in;
  logic [NB-1:0]       wmask_in;
  logic [DATA_W-1:0]   wdata_in;
  logic [ADDR_W-1:0]   aligned_in;

  // Shift a raw memory word down to the accessed lane and sign/zero extend.
  function automatic logic [DATA_W-1:0] load_extend(
    input logic [DATA_W-1:0] raw,
    input logic [OFF_W-1:0]  off,
    input logic [1:0]        size,
    input logic              uns
  );
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] ext;
    sh  = raw >> {off, 3'b000};
    ext = sh;
    case (size)
      2'b00: begin
        ext      = {DATA_W{~uns & sh[7]}};
        ext[7:0] = sh[7:0];
      end
      2'b01: begin
        ext       = {DATA_W{~uns & sh[15]}};
        ext[15:0] = sh[15:0];
      end
      2'b10: begin
        ext       = {DATA_W{~uns & sh[31]}};
        ext[31:0] = sh[31:0];
      end
      default: ext = sh;
    endcase
    return ext;
  endfunction

  // Decode alignment, lane mask and shifted store data of the incoming request.
  always_comb begin
    off_in     = req_addr[OFF_W-1:0];
    aligned_in = req_addr & ~ADDR_W'(NB - 1);
    wdata_in   = req_wdata << {off_in, 3'b000};
    bad_in     = 1'b0;
    wmask_in   = '0;
    case (req_size)
      2'b00: wmask_in = NB'(1) << off_in;
      2'b01: begin
        bad_in   = req_addr[0];
        wmask_in = NB'(3) << off_in;
      end
      2'b10: begin
        bad_in   = |req_addr[1:0];
        wmask_in = NB'(15) << off_in;
      end
      default: begin
        bad_in   = (DATA_W == 32) ? 1'b1 : (|req_addr[2:0]);
        wmask_in = '1;
      end
    endcase
    if (!req_wen) begin
      wmask_in = '0;
    end
  end

  // Next-state and next-output logic; every output is a flop loaded from here.
  always_comb begin
    state_next      = state_reg;
    wen_next        = wen_reg;
    size_next       = size_reg;
    uns_next        = uns_reg;
    off_next        = off_reg;
    cnt_next        = cnt_reg;
    req_ready_next  = req_ready_reg;
    resp_valid_next = resp_valid_reg;
    rdata_next      = rdata_reg;
    err_next        = err_reg;
    mreq_valid_next = mreq_valid_reg;
    mreq_wen_next   = mreq_wen_reg;
    maddr_next      = maddr_reg;
    mwdata_next     = mwdata_reg;
    mwmask_next     = mwmask_reg;

    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          wen_next       = req_wen;
          size_next      = req_size;
          uns_next       = req_unsigned;
          off_next       = off_in;
          cnt_next       = '0;
          req_ready_next = 1'b0;
          rdata_next     = '0;
          if (bad_in) begin
            // Rejected locally: no memory traffic, straight to an error response.
            state_next      = RESP;
            err_next        = 1'b1;
            resp_valid_next = 1'b1;
          end else begin
            state_next      = REQ;
            err_next        = 1'b0;
            mreq_valid_next = 1'b1;
            mreq_wen_next   = req_wen;
            maddr_next      = aligned_in;
            mwdata_next     = wdata_in;
            mwmask_next     = wmask_in;
          end
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          mreq_valid_next = 1'b0;
          mreq_wen_next   = 1'b0;
          cnt_next        = '0;
          if (mem_resp_valid) begin
            // Response in the same cycle as the accept skips WAIT entirely.
            state_next      = RESP;
            resp_valid_next = 1'b1;
            rdata_next      = wen_reg ? '0 : load_extend(mem_resp_rdata, off_reg, size_reg, uns_reg);
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (mem_resp_valid) begin
          state_next      = RESP;
          resp_valid_next = 1'b1;
          rdata_next      = wen_reg ? '0 : load_extend(mem_resp_rdata, off_reg, size_reg, uns_reg);
        end else if (TIMEOUT > 0 && (cnt_reg + CNT_W'(1)) >= CNT_W'(TIMEOUT)) begin
          state_next      = RESP;
          resp_valid_next = 1'b1;
          err_next        = 1'b1;
          rdata_next      = '0;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_next      = IDLE;
          resp_valid_next = 1'b0;
          req_ready_next  = 1'b1;
          rdata_next      = '0;
          err_next        = 1'b0;
          cnt_next        = '0;
        end
      end
      default: begin
        state_next      = IDLE;
        req_ready_next  = 1'b1;
        resp_valid_next = 1'b0;
        mreq_valid_next = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight transaction at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      wen_reg        <= 1'b0;
      size_reg       <= 2'b00;
      uns_reg        <= 1'b0;
      off_reg        <= '0;
      cnt_reg        <= '0;
      req_ready_reg  <= 1'b1;
      resp_valid_reg <= 1'b0;
      rdata_reg      <= '0;
      err_reg        <= 1'b0;
      mreq_valid_reg <= 1'b0;
      mreq_wen_reg   <= 1'b0;
      maddr_reg      <= '0;
      mwdata_reg     <= '0;
      mwmask_reg     <= '0;
    end else begin
      state_reg      <= state_next;
      wen_reg        <= wen_next;
      size_reg       <= size_next;
      uns_reg        <= uns_next;
      off_reg        <= off_next;
      cnt_reg        <= cnt_next;
      req_ready_reg  <= req_ready_next;
      resp_valid_reg <= resp_valid_next;
      rdata_reg      <= rdata_next;
      err_reg        <= err_next;
      mreq_valid_reg <= mreq_valid_next;
      mreq_wen_reg   <= mreq_wen_next;
      maddr_reg      <= maddr_next;
      mwdata_reg     <= mwdata_next;
      mwmask_reg     <= mwmask_next;
    end
  end

  assign req_ready     = req_ready_reg;
  assign resp_valid    = resp_valid_reg;
  assign resp_rdata    = rdata_reg;
  assign resp_err      = err_reg;
  assign mem_req_valid = mreq_valid_reg;
  assign mem_req_wen   = mreq_wen_reg;
  assign mem_req_addr  = maddr_reg;
  assign mem_req_wdata = mwdata_reg;
  assign mem_req_wmask = mwmask_reg;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed bench for lsu_ctrl (DATA_W=32, TIMEOUT=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_lsu_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;

  int checks = 0;
  int errors = 0;

  lsu_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request for a single cycle starting at the current negedge.
  task automatic issue(input logic wen, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1; req_wen = wen; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 0; req_wen = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
    resp_ready = 0; mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = 0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %0b exp 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %0b exp 0", resp_valid); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_req_valid: got %0b exp 0", mem_req_valid); end
    checks++; if ({resp_rdata, resp_err, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask} !== '0) begin
      errors++; $display("FAIL reset_outputs_zero: rdata=%h err=%0b addr=%h wen=%0b wdata=%h mask=%h exp all 0",
                         resp_rdata, resp_err, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask);
    end
    rst = 1'b1;
    @(negedge clk);
    $display("reset: req_ready=%0b resp_valid=%0b mem_req_valid=%0b", req_ready, resp_valid, mem_req_valid);
  endtask

  // Zero-wait loads: memory accepts and responds in the same cycle.
  task automatic test_loads;
    logic [31:0] v_addr [5] = '{32'h8000_0003, 32'h8000_0003, 32'h8000_0002, 32'h8000_0004, 32'h8000_0000};
    logic [1:0]  v_size [5] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b01};
    logic        v_uns  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] v_raw  [5] = '{32'h8011_2233, 32'h8011_2233, 32'h8001_0000, 32'h1234_5678, 32'h0000_F00F};
    logic [31:0] v_exp  [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h1234_5678, 32'h0000_F00F};
    logic [31:0] v_algn [5] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0004, 32'h8000_0000};
    for (int i = 0; i < 5; i++) begin
      issue(1'b0, v_size[i], v_uns[i], v_addr[i], 32'h0);
      checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL load%0d_mem_req_valid: got %0b exp 1", i, mem_req_valid); end
      checks++; if (mem_req_addr !== v_algn[i]) begin errors++; $display("FAIL load%0d_mem_req_addr: got %h exp %h", i, mem_req_addr, v_algn[i]); end
      checks++; if (mem_req_wmask !== 4'b0000 || mem_req_wen !== 1'b0) begin
        errors++; $display("FAIL load%0d_wmask_wen: got mask=%b wen=%0b exp 0000/0", i, mem_req_wmask, mem_req_wen);
      end
      mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_rdata = v_raw[i];
      @(negedge clk);
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
      checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL load%0d_resp_valid: got %0b exp 1", i, resp_valid); end
      checks++; if (resp_rdata !== v_exp[i] || resp_err !== 1'b0) begin
        errors++; $display("FAIL load%0d_rdata: got %h err=%0b exp %h err=0", i, resp_rdata, resp_err, v_exp[i]);
      end
      $display("load addr=%h size=%0d uns=%0b raw=%h -> rdata=%h err=%0b", v_addr[i], v_size[i], v_uns[i], v_raw[i], resp_rdata, resp_err);
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
        errors++; $display("FAIL load%0d_return_idle: got resp_valid=%0b req_ready=%0b exp 0/1", i, resp_valid, req_ready);
      end
    end
  endtask

  // Stores with lane shifting; acknowledge arrives after a short WAIT.
  task automatic test_stores;
    logic [31:0] v_addr [2] = '{32'h8000_0002, 32'h8000_0001};
    logic [1:0]  v_size [2] = '{2'b01, 2'b00};
    logic [31:0] v_wd   [2] = '{32'h0000_ABCD, 32'h0000_005A};
    logic [3:0]  v_mask [2] = '{4'b1100, 4'b0010};
    logic [31:0] v_mwd  [2] = '{32'hABCD_0000, 32'h0000_5A00};
    for (int i = 0; i < 2; i++) begin
      issue(1'b1, v_size[i], 1'b0, v_addr[i], v_wd[i]);
      checks++; if (mem_req_wmask !== v_mask[i]) begin errors++; $display("FAIL store%0d_wmask: got %b exp %b", i, mem_req_wmask, v_mask[i]); end
      checks++; if (mem_req_wdata !== v_mwd[i]) begin errors++; $display("FAIL store%0d_wdata: got %h exp %h", i, mem_req_wdata, v_mwd[i]); end
      checks++; if (mem_req_wen !== 1'b1 || mem_req_addr !== 32'h8000_0000) begin
        errors++; $display("FAIL store%0d_wen_addr: got wen=%0b addr=%h exp 1/80000000", i, mem_req_wen, mem_req_addr);
      end
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      checks++; if (mem_req_valid !== 1'b0 || resp_valid !== 1'b0) begin
        errors++; $display("FAIL store%0d_wait: got mem_req_valid=%0b resp_valid=%0b exp 0/0", i, mem_req_valid, resp_valid);
      end
      @(negedge clk);
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL store%0d_no_early_resp: got %0b exp 0", i, resp_valid); end
      mem_resp_valid = 1'b1; mem_resp_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
        errors++; $display("FAIL store%0d_resp: got valid=%0b rdata=%h err=%0b exp 1/00000000/0", i, resp_valid, resp_rdata, resp_err);
      end
      $display("store addr=%h size=%0d wdata=%h -> mask=%b mwdata=%h", v_addr[i], v_size[i], v_wd[i], v_mask[i], v_mwd[i]);
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
    end
  endtask

  // Misaligned or illegal-size accesses answer with an error and never touch memory.
  task automatic test_misaligned;
    logic [31:0] v_addr [3] = '{32'h8000_0001, 32'h8000_0003, 32'h8000_0000};
    logic [1:0]  v_size [3] = '{2'b10, 2'b01, 2'b11};
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, v_size[i], 1'b0, v_addr[i], 32'h0);
      checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin
        errors++; $display("FAIL misalign%0d_err: got valid=%0b err=%0b exp 1/1", i, resp_valid, resp_err);
      end
      checks++; if (mem_req_valid !== 1'b0 || resp_rdata !== 32'h0) begin
        errors++; $display("FAIL misalign%0d_no_mem: got mem_req_valid=%0b rdata=%h exp 0/00000000", i, mem_req_valid, resp_rdata);
      end
      $display("misaligned addr=%h size=%0d -> err=%0b", v_addr[i], v_size[i], resp_err);
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
    end
  endtask

  // Memory never answers: error after exactly four WAIT cycles, stray response ignored.
  task automatic test_timeout;
    issue(1'b0, 2'b10, 1'b0, 32'h8000_0000, 32'h0);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL timeout_early_%0d: got resp_valid=%0b exp 0", i, resp_valid); end
    end
    @(negedge clk);
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'h0) begin
      errors++; $display("FAIL timeout_resp: got valid=%0b err=%0b rdata=%h exp 1/1/00000000", resp_valid, resp_err, resp_rdata);
    end
    $display("timeout: resp_valid=%0b resp_err=%0b", resp_valid, resp_err);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1111_2222;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
      errors++; $display("FAIL stray_resp_ignored: got resp_valid=%0b req_ready=%0b mem_req_valid=%0b exp 0/1/0", resp_valid, req_ready, mem_req_valid);
    end
    $display("stray mem_resp in IDLE: resp_valid=%0b req_ready=%0b", resp_valid, req_ready);
  endtask

  // Back-pressure on both sides, then an asynchronous reset in the middle of WAIT.
  task automatic test_stall_and_reset;
    issue(1'b1, 2'b10, 1'b0, 32'h8000_0010, 32'h1122_3344);
    for (int i = 0; i < 5; i++) begin
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0010 || mem_req_wdata !== 32'h1122_3344
                    || mem_req_wmask !== 4'hF || mem_req_wen !== 1'b1) begin
        errors++; $display("FAIL stall%0d_fields: got v=%0b addr=%h wdata=%h mask=%h wen=%0b exp 1/80000010/11223344/f/1",
                           i, mem_req_valid, mem_req_addr, mem_req_wdata, mem_req_wmask, mem_req_wen);
      end
      @(negedge clk);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
        errors++; $display("FAIL resp_hold%0d: got valid=%0b rdata=%h err=%0b exp 1/00000000/0", i, resp_valid, resp_rdata, resp_err);
      end
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    $display("stalled store addr=80000010 completed: resp_valid=%0b", resp_valid);
    issue(1'b0, 2'b10, 1'b0, 32'h8000_0020, 32'h0);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
      errors++; $display("FAIL async_reset: got req_ready=%0b resp_valid=%0b mem_req_valid=%0b exp 1/0/0", req_ready, resp_valid, mem_req_valid);
    end
    checks++; if (mem_req_addr !== 32'h0) begin errors++; $display("FAIL async_reset_addr: got %h exp 00000000", mem_req_addr); end
    $display("async reset mid-WAIT: req_ready=%0b resp_valid=%0b", req_ready, resp_valid);
    @(negedge clk);
    rst = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_idle: got resp_valid=%0b req_ready=%0b exp 0/1", resp_valid, req_ready);
    end
  endtask

  initial begin
    test_reset;
    test_loads;
    test_stores;
    test_misaligned;
    test_timeout;
    test_stall_and_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Parametrised load/store unit for the NPC core. It sits between the EXU/WBU and the data-memory port, and replaces the fixed single-cycle LSU. It accepts one load or store at a time over a valid/ready handshake and performs byte-lane alignment, write-mask generation, and sign/zero extension. It drives a handshaked memory request/response channel of arbitrary latency, and reports misaligned accesses and memory timeouts as errors.

Parameters:
ADDR_W, 32, address width in bits.
DATA_W, 32, memory/register data width; legal values 32 or 64.
TIMEOUT, 0, max cycles spent in WAIT before an error response; 0 disables the timeout.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset, asynchronous, active-low.
req_valid  in  1  core request valid.
req_ready  out  1  LSU can accept a request.
req_wen  in  1  1 = store, 0 = load.
req_size  in  2  00 byte, 01 half, 10 word, 11 double (legal only when DATA_W=64).
req_unsigned  in  1  load zero-extends when set; ignored for stores.
req_addr  in  ADDR_W  byte address.
req_wdata  in  DATA_W  store data, LSB-justified.
resp_valid  out  1  response valid.
resp_ready  in  1  core accepts the response.
resp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
resp_err  out  1  misaligned access, illegal size, or timeout.
mem_req_valid  out  1  memory request valid.
mem_req_ready  in  1  memory accepts the request.
mem_req_addr  out  ADDR_W  address aligned down to DATA_W/8 bytes.
mem_req_wen  out  1  store strobe.
mem_req_wdata  out  DATA_W  req_wdata shifted to its byte lane.
mem_req_wmask  out  DATA_W/8  byte-lane write enables; all zero for loads.
mem_resp_valid  in  1  memory response (read data, or write acknowledge).
mem_resp_rdata  in  DATA_W  raw memory word.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs 0 except req_ready=1. The timeout counter and request registers are cleared. An in-flight transaction is dropped; a late mem_resp_valid after reset release is ignored in IDLE.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: req_ready=1. On req_valid, latch wen, size, unsigned, addr and wdata.
  - If the access is misaligned (half: addr[0]; word: addr[1:0]; double: addr[2:0]) or size=11 with DATA_W=32: go to RESP with resp_err=1. No memory traffic.
  - Otherwise go to REQ.
- REQ: mem_req_valid=1. The address, wen, wdata and wmask are held stable until mem_req_ready. When mem_req_valid and mem_req_ready are both high, go to WAIT. If mem_resp_valid arrives in the same cycle as the accept, go directly to RESP (minimum latency).
- WAIT: on mem_resp_valid, capture the response and go to RESP. The counter increments each WAIT cycle. If TIMEOUT>0 and the counter reaches TIMEOUT, go to RESP with resp_err=1, resp_rdata=0. A later stray mem_resp_valid is ignored.
- RESP: resp_valid=1, with resp_rdata and resp_err held until resp_ready, then return to IDLE. req_ready=0 in RESP; there are no back-to-back requests, so request-to-request spacing is at least 3 cycles.
- Lane offset: off = addr mod (DATA_W/8).
- Write mask: byte 1<<off; half 3<<off; word 0xF<<off; double all ones.
- Write data: mem_req_wdata = req_wdata << (8*off).
- Loads: raw = mem_resp_rdata >> (8*off), truncated to size. Sign-extend from the size MSB unless req_unsigned. A double load is passed through unchanged.
- Stores: resp_rdata=0. The response is issued on mem_resp_valid (write acknowledge).
- Latency: at least 2 cycles from request accept to resp_valid with zero-wait memory.
- Outputs are registered and no output depends combinationally on req_* inputs.

Test Plan:
- DATA_W=32; load byte at addr 0x8000_0003; mem_rdata=0x80_11_22_33 -> mem_req_addr=0x8000_0000, mem_req_wmask=0, resp_rdata=0xFFFF_FF80, resp_err=0.
- Same access with req_unsigned=1 -> resp_rdata=0x0000_0080. Half load at 0x...2 with rdata 0x8001_0000 -> resp_rdata=0xFFFF_8001 (signed).
- Store half 0xABCD at 0x8000_0002 -> mem_req_wmask=0b1100, mem_req_wdata=0xABCD_0000. resp_valid follows mem_resp_valid, with resp_rdata=0.
- Word load at 0x8000_0001 -> resp_valid=1, resp_err=1 one cycle after the accept; mem_req_valid never asserts.
- TIMEOUT=4, memory never responds -> resp_err=1 after 4 WAIT cycles. A stray mem_resp_valid injected afterwards in IDLE is ignored.
- mem_req_ready held low for 5 cycles, resp_ready low for 3 cycles, then rst pulsed low mid-WAIT -> request fields stable throughout. After reset, req_ready=1, resp_valid=0 and mem_req_valid=0 immediately (asynchronous).
